// File: rtl/cpc_ram_pkg.sv
// cpc_ram_pkg: shared types and constants for the CPC expansion RAM controller
package cpc_ram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WAIT_END
  } state_e;
  localparam logic [1:0] CFG_CODE = 2'b11;
  localparam int PAGE_W = 2;
  localparam logic [2:0] MODE_0 = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;
  localparam logic [2:0] MODE_6 = 3'd6;
  localparam logic [2:0] MODE_7 = 3'd7;
endpackage

// File: rtl/cpc_ram_map.sv
// cpc_ram_map: translates the RAM configuration mode and the 16K block into an expansion page
module cpc_ram_map
  import cpc_ram_pkg::*;
(
  input  logic [2:0]        mode,
  input  logic [1:0]        blk,
  output logic              ext,
  output logic [PAGE_W-1:0] page
);
  logic [2:0] hi_page;
  assign hi_page = mode - MODE_4;
  // mode 0 keeps internal RAM; modes 1/3 swap block 3; mode 2 maps all; modes 4-7 swap block 1
  always_comb begin
    ext = 1'b0;
    page = blk;
    if (mode == MODE_0) begin
      ext = 1'b0;
    end else if (mode == MODE_2) begin
      ext = 1'b1;
    end else if (mode == MODE_1 || mode == MODE_3) begin
      ext = (blk == 2'd3);
      page = 2'd3;
    end else if (mode inside {MODE_4, MODE_5, MODE_6, MODE_7}) begin
      ext = (blk == 2'd1);
      page = hi_page[PAGE_W-1:0];
    end
  end
endmodule

// File: rtl/cpc_ram_ctrl.sv
// cpc_ram_ctrl: Z80 bus decoder, 6128 RAM config register and SRAM strobe sequencer
module cpc_ram_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int WE_DELAY  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 BUSRESET_B,
  input  logic                 MREQ_B,
  input  logic                 IOREQ_B,
  input  logic                 RD_B,
  input  logic                 WR_B,
  input  logic                 M1_B,
  input  logic                 RFSH_B,
  input  logic                 ROMEN_B,
  input  logic                 A15,
  input  logic                 A14,
  input  logic [7:0]           D,
  output logic [BANK_BITS+1:0] HIADR,
  output logic                 RAMCS_B,
  output logic                 RAMOE_B,
  output logic                 RAMWE_B,
  output logic                 RAMDIS
);
  state_e state_q, state_d;
  logic [BANK_BITS-1:0] cfg_bank_q, cfg_bank_d;
  logic [2:0] cfg_mode_q, cfg_mode_d;
  logic [BANK_BITS+1:0] hiadr_q, hiadr_d;
  logic ramcs_b_q, ramcs_b_d;
  logic ramoe_b_q, ramoe_b_d;
  logic ramwe_b_q, ramwe_b_d;
  logic ramdis_q, ramdis_d;
  logic io_wr_q, io_wr_d;
  logic [1:0] we_cnt_q, we_cnt_d;
  logic io_wr, cfg_hit, ext, cyc_start, rd_hit, wr_hit;
  logic [PAGE_W-1:0] page;
  assign io_wr = !IOREQ_B && !WR_B && M1_B && !A15;
  // a simultaneous MREQ_B means a broken bus cycle; the memory side wins
  assign cfg_hit = io_wr && !io_wr_q && (D[7:6] == CFG_CODE) && MREQ_B;
  assign cyc_start = !MREQ_B && RFSH_B && (!RD_B || !WR_B);
  assign rd_hit = ext && !RD_B && ROMEN_B;
  assign wr_hit = ext && !WR_B;
  cpc_ram_map u_map (
    .mode (cfg_mode_q),
    .blk  ({A15, A14}),
    .ext  (ext),
    .page (page)
  );
  // next-state: config capture, strobe sequencing and synchronous bus reset
  always_comb begin
    state_d = state_q;
    cfg_bank_d = cfg_bank_q;
    cfg_mode_d = cfg_mode_q;
    hiadr_d = hiadr_q;
    ramcs_b_d = ramcs_b_q;
    ramoe_b_d = ramoe_b_q;
    ramwe_b_d = ramwe_b_q;
    ramdis_d = ramdis_q;
    we_cnt_d = we_cnt_q;
    io_wr_d = io_wr;
    if (cfg_hit) begin
      cfg_bank_d = BANK_BITS'(D[5:3]);
      cfg_mode_d = D[2:0];
    end
    case (state_q)
      ST_IDLE: if (cyc_start) begin
        if (rd_hit || wr_hit) begin
          hiadr_d = {cfg_bank_q, page};
          ramdis_d = 1'b1;
          ramcs_b_d = 1'b0;
        end
        if (rd_hit) begin
          ramoe_b_d = 1'b0;
          state_d = ST_RD;
        end else if (wr_hit) begin
          we_cnt_d = 2'(WE_DELAY);
          ramwe_b_d = (WE_DELAY != 0);
          state_d = ST_WR;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      ST_RD: if (MREQ_B) begin
        ramcs_b_d = 1'b1;
        ramoe_b_d = 1'b1;
        ramdis_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_WR: if (MREQ_B || WR_B) begin
        ramwe_b_d = 1'b1;
        ramcs_b_d = 1'b1;
        ramdis_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        // WE lands WE_DELAY edges after CS: the edge that empties the counter also strobes
        we_cnt_d = (we_cnt_q != 2'd0) ? we_cnt_q - 2'd1 : we_cnt_q;
        if (we_cnt_q <= 2'd1) ramwe_b_d = 1'b0;
      end
      ST_WAIT_END: if (MREQ_B) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!BUSRESET_B) begin
      state_d = ST_IDLE;
      cfg_bank_d = '0;
      cfg_mode_d = '0;
      hiadr_d = '0;
      ramcs_b_d = 1'b1;
      ramoe_b_d = 1'b1;
      ramwe_b_d = 1'b1;
      ramdis_d = 1'b0;
      we_cnt_d = '0;
      io_wr_d = 1'b0;
    end
  end
  // state register with asynchronous board reset
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      cfg_bank_q <= '0;
      cfg_mode_q <= '0;
      hiadr_q <= '0;
      ramcs_b_q <= 1'b1;
      ramoe_b_q <= 1'b1;
      ramwe_b_q <= 1'b1;
      ramdis_q <= 1'b0;
      we_cnt_q <= '0;
      io_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_bank_q <= cfg_bank_d;
      cfg_mode_q <= cfg_mode_d;
      hiadr_q <= hiadr_d;
      ramcs_b_q <= ramcs_b_d;
      ramoe_b_q <= ramoe_b_d;
      ramwe_b_q <= ramwe_b_d;
      ramdis_q <= ramdis_d;
      we_cnt_q <= we_cnt_d;
      io_wr_q <= io_wr_d;
    end
  end
  assign HIADR = hiadr_q;
  assign RAMCS_B = ramcs_b_q;
  assign RAMOE_B = ramoe_b_q;
  assign RAMWE_B = ramwe_b_q;
  assign RAMDIS = ramdis_q;
endmodule

// File: tb/tb_cpc_ram_ctrl.sv
// tb_cpc_ram_ctrl: checks two controller instances (WE_DELAY 1 and 2) against a bus-cycle reference model
module tb_cpc_ram_ctrl;
  localparam int K_IDLE = 0;
  localparam int K_RD = 1;
  localparam int K_WR = 2;
  localparam int K_OTHER = 3;
  logic CLK = 1'b0;
  logic RESET_B, BUSRESET_B, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B, A15, A14;
  logic [7:0] D;
  logic [4:0] hi0, hi1;
  logic cs0, oe0, we0, dis0, cs1, oe1, we1, dis1;
  logic [2:0] tm_mode;
  logic [1:0] tm_blk, tm_page;
  logic tm_ext;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int kind; int age; logic [4:0] hi;} cyc_t;
  cyc_t m[2];
  int dly[2];
  logic [2:0] bank_m, mode_m;
  logic io_prev;
  typedef struct {logic [2:0] mode; logic [1:0] blk; logic ext; logic [1:0] page;} mv_t;
  mv_t mv[15];

  always #5 CLK = ~CLK;

  cpc_ram_ctrl #(.BANK_BITS(3), .WE_DELAY(1)) u_dut0 (
    .CLK(CLK), .RESET_B(RESET_B), .BUSRESET_B(BUSRESET_B), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B),
    .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B), .ROMEN_B(ROMEN_B), .A15(A15), .A14(A14),
    .D(D), .HIADR(hi0), .RAMCS_B(cs0), .RAMOE_B(oe0), .RAMWE_B(we0), .RAMDIS(dis0)
  );
  cpc_ram_ctrl #(.BANK_BITS(3), .WE_DELAY(2)) u_dut1 (
    .CLK(CLK), .RESET_B(RESET_B), .BUSRESET_B(BUSRESET_B), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B),
    .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B), .ROMEN_B(ROMEN_B), .A15(A15), .A14(A14),
    .D(D), .HIADR(hi1), .RAMCS_B(cs1), .RAMOE_B(oe1), .RAMWE_B(we1), .RAMDIS(dis1)
  );
  cpc_ram_map u_map (.mode(tm_mode), .blk(tm_blk), .ext(tm_ext), .page(tm_page));

  // {ext, page} straight from the mapping rules
  function automatic logic [2:0] ref_map(input logic [2:0] mode, input logic [1:0] blk);
    logic [2:0] p;
    p = mode - 3'd4;
    if (mode == 3'd2) return {1'b1, blk};
    if ((mode == 3'd1 || mode == 3'd3) && blk == 2'd3) return 3'b111;
    if (mode >= 3'd4 && blk == 2'd1) return {1'b1, p[1:0]};
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    bank_m = '0;
    mode_m = '0;
    io_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m[i].kind = K_IDLE;
      m[i].age = 0;
      m[i].hi = '0;
    end
  endtask

  // one rising edge of the bus as the controller should see it
  task automatic model_edge();
    logic io_now;
    logic [2:0] em;
    if (!RESET_B || !BUSRESET_B) begin
      model_reset();
      return;
    end
    io_now = !IOREQ_B && !WR_B && M1_B && !A15;
    em = ref_map(mode_m, {A15, A14});
    for (int i = 0; i < 2; i++) begin
      case (m[i].kind)
        K_IDLE: if (!MREQ_B && RFSH_B && (!RD_B || !WR_B)) begin
          if (em[2] && !RD_B && ROMEN_B) begin
            m[i].kind = K_RD;
            m[i].hi = {bank_m[2:0], em[1:0]};
          end else if (em[2] && !WR_B) begin
            m[i].kind = K_WR;
            m[i].age = 0;
            m[i].hi = {bank_m[2:0], em[1:0]};
          end else begin
            m[i].kind = K_OTHER;
          end
        end
        K_WR: if (MREQ_B || WR_B) m[i].kind = K_IDLE; else m[i].age++;
        default: if (MREQ_B) m[i].kind = K_IDLE;
      endcase
    end
    if (io_now && !io_prev && D[7:6] == 2'b11 && MREQ_B) begin
      bank_m = D[5:3];
      mode_m = D[2:0];
    end
    io_prev = io_now;
  endtask

  task automatic check_all();
    logic [7:0] ecs[2], eoe[2], ewe[2], edis[2];
    for (int i = 0; i < 2; i++) begin
      edis[i] = 8'(m[i].kind == K_RD || m[i].kind == K_WR);
      ecs[i] = 8'(!(m[i].kind == K_RD || m[i].kind == K_WR));
      eoe[i] = 8'(m[i].kind != K_RD);
      ewe[i] = 8'(!(m[i].kind == K_WR && m[i].age >= dly[i]));
    end
    chk("hiadr0", 8'(hi0), 8'(m[0].hi));
    chk("ramcs0", 8'(cs0), ecs[0]);
    chk("ramoe0", 8'(oe0), eoe[0]);
    chk("ramwe0", 8'(we0), ewe[0]);
    chk("ramdis0", 8'(dis0), edis[0]);
    chk("hiadr1", 8'(hi1), 8'(m[1].hi));
    chk("ramcs1", 8'(cs1), ecs[1]);
    chk("ramoe1", 8'(oe1), eoe[1]);
    chk("ramwe1", 8'(we1), ewe[1]);
    chk("ramdis1", 8'(dis1), edis[1]);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle_bus();
    MREQ_B = 1'b1;
    IOREQ_B = 1'b1;
    RD_B = 1'b1;
    WR_B = 1'b1;
    M1_B = 1'b1;
    RFSH_B = 1'b1;
    ROMEN_B = 1'b1;
  endtask

  task automatic io_write(input logic a15, input logic [7:0] d, input logic m1);
    A15 = a15;
    A14 = 1'b1;
    D = d;
    M1_B = m1;
    IOREQ_B = 1'b0;
    cycle();
    WR_B = 1'b0;
    cycle();
    cycle();
    idle_bus();
    cycle();
  endtask

  task automatic mem_cycle(input logic wr, input logic a15, input logic a14, input logic romen, input int hold);
    A15 = a15;
    A14 = a14;
    ROMEN_B = romen;
    D = 8'($urandom);
    MREQ_B = 1'b0;
    cycle();
    if (wr) WR_B = 1'b0; else RD_B = 1'b0;
    repeat (hold) cycle();
    idle_bus();
    cycle();
  endtask

  task automatic refresh();
    MREQ_B = 1'b0;
    RFSH_B = 1'b0;
    RD_B = 1'b0;
    cycle();
    cycle();
    idle_bus();
    cycle();
  endtask

  task automatic bus_reset();
    BUSRESET_B = 1'b0;
    cycle();
    BUSRESET_B = 1'b1;
    cycle();
  endtask

  initial begin
    dly[0] = 1;
    dly[1] = 2;
    mv[0] = '{3'd0, 2'd3, 1'b0, 2'd0};
    mv[1] = '{3'd1, 2'd3, 1'b1, 2'd3};
    mv[2] = '{3'd1, 2'd1, 1'b0, 2'd0};
    mv[3] = '{3'd2, 2'd0, 1'b1, 2'd0};
    mv[4] = '{3'd2, 2'd1, 1'b1, 2'd1};
    mv[5] = '{3'd2, 2'd2, 1'b1, 2'd2};
    mv[6] = '{3'd2, 2'd3, 1'b1, 2'd3};
    mv[7] = '{3'd3, 2'd3, 1'b1, 2'd3};
    mv[8] = '{3'd3, 2'd1, 1'b0, 2'd0};
    mv[9] = '{3'd4, 2'd1, 1'b1, 2'd0};
    mv[10] = '{3'd5, 2'd1, 1'b1, 2'd1};
    mv[11] = '{3'd6, 2'd1, 1'b1, 2'd2};
    mv[12] = '{3'd7, 2'd1, 1'b1, 2'd3};
    mv[13] = '{3'd7, 2'd2, 1'b0, 2'd0};
    mv[14] = '{3'd4, 2'd0, 1'b0, 2'd0};
    for (int i = 0; i < 15; i++) begin
      tm_mode = mv[i].mode;
      tm_blk = mv[i].blk;
      #1;
      chk("map_ext", 8'(tm_ext), 8'(mv[i].ext));
      if (mv[i].ext) chk("map_page", 8'(tm_page), 8'(mv[i].page));
    end
    idle_bus();
    BUSRESET_B = 1'b1;
    A15 = 1'b0;
    A14 = 1'b0;
    D = 8'h00;
    RESET_B = 1'b0;
    model_reset();
    repeat (2) cycle();
    chk("rst_cs", 8'(cs0), 8'h1);
    chk("rst_dis", 8'(dis0), 8'h0);
    RESET_B = 1'b1;
    cycle();
    io_write(1'b0, 8'hC2, 1'b1);
    A15 = 1'b0;
    A14 = 1'b1;
    ROMEN_B = 1'b1;
    MREQ_B = 1'b0;
    cycle();
    chk("tp1_idle_cs", 8'(cs0), 8'h1);
    RD_B = 1'b0;
    cycle();
    chk("tp1_hiadr", 8'(hi0), 8'h01);
    chk("tp1_cs", 8'(cs0), 8'h0);
    chk("tp1_oe", 8'(oe0), 8'h0);
    chk("tp1_dis", 8'(dis0), 8'h1);
    cycle();
    idle_bus();
    cycle();
    chk("tp1_rel_cs", 8'(cs0), 8'h1);
    chk("tp1_rel_oe", 8'(oe0), 8'h1);
    chk("tp1_rel_dis", 8'(dis0), 8'h0);
    io_write(1'b0, 8'hEE, 1'b1);
    A15 = 1'b0;
    A14 = 1'b1;
    MREQ_B = 1'b0;
    cycle();
    WR_B = 1'b0;
    cycle();
    chk("tp2_hiadr", 8'(hi0), 8'h16);
    chk("tp2_cs", 8'(cs0), 8'h0);
    chk("tp2_we_wait", 8'(we0), 8'h1);
    cycle();
    chk("tp2_we", 8'(we0), 8'h0);
    cycle();
    idle_bus();
    cycle();
    chk("tp2_we_rel", 8'(we0), 8'h1);
    chk("tp2_cs_rel", 8'(cs0), 8'h1);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b1, 2);
    io_write(1'b0, 8'h8D, 1'b1);
    io_write(1'b1, 8'hC1, 1'b1);
    io_write(1'b0, 8'hC1, 1'b0);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b1, 2);
    mem_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2);
    io_write(1'b0, 8'hC1, 1'b1);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2);
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3);
    chk("tp4_hiadr", 8'(hi0), 8'h03);
    A15 = 1'b1;
    A14 = 1'b1;
    refresh();
    A15 = 1'b0;
    A14 = 1'b1;
    D = 8'hC6;
    MREQ_B = 1'b0;
    IOREQ_B = 1'b0;
    cycle();
    WR_B = 1'b0;
    repeat (2) cycle();
    idle_bus();
    cycle();
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b1, 2);
    io_write(1'b0, 8'hC2, 1'b1);
    mem_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1);
    mem_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2);
    io_write(1'b0, 8'hFD, 1'b1);
    A15 = 1'b0;
    A14 = 1'b1;
    MREQ_B = 1'b0;
    cycle();
    WR_B = 1'b0;
    repeat (2) cycle();
    chk("tp5_we_on", 8'(we0), 8'h0);
    #2 RESET_B = 1'b0;
    #1 model_reset();
    check_all();
    chk("tp5_async_we", 8'(we0), 8'h1);
    chk("tp5_async_cs", 8'(cs0), 8'h1);
    idle_bus();
    cycle();
    RESET_B = 1'b1;
    cycle();
    mem_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2);
    io_write(1'b0, 8'hD2, 1'b1);
    bus_reset();
    mem_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2);
    chk("tp5_bus_dis", 8'(dis0), 8'h0);
    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 2) begin
        io_write(1'($urandom_range(0, 3) == 0),
                 {($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom), 6'($urandom)},
                 1'($urandom_range(0, 5) != 0));
      end else if (op < 5) begin
        mem_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(1, 3));
      end else if (op < 8) begin
        mem_cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 4));
      end else if (op == 8) begin
        A15 = 1'($urandom);
        A14 = 1'($urandom);
        refresh();
      end else begin
        bus_reset();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
